// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt controller.
//  - Source indices of the 12 timer strobes (channel c: CMIA=3c, CMIB=3c+1, OVI=3c+2)
//  - Request FSM state encoding
package timer_pkg;

  localparam int unsigned SRC_CMIA0 = 0;
  localparam int unsigned SRC_CMIB0 = 1;
  localparam int unsigned SRC_OVI0  = 2;
  localparam int unsigned SRC_CMIA1 = 3;
  localparam int unsigned SRC_CMIB1 = 4;
  localparam int unsigned SRC_OVI1  = 5;
  localparam int unsigned SRC_CMIA2 = 6;
  localparam int unsigned SRC_CMIB2 = 7;
  localparam int unsigned SRC_OVI2  = 8;
  localparam int unsigned SRC_CMIA3 = 9;
  localparam int unsigned SRC_CMIB3 = 10;
  localparam int unsigned SRC_OVI3  = 11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Bus bundle between the timer interrupt controller and its neighbours.
//  master : strobe sources, register writes and CPU acknowledge (driven into the controller)
//  slave  : the controller itself (drives irq_req/irq_vec and register readback)
interface timer_irq_ctrl_if #(
  parameter int unsigned NUM_SRC   = 12,
  parameter int unsigned VEC_WIDTH = 4
);
  logic [NUM_SRC-1:0]   src_in;
  logic                 en_we;
  logic [NUM_SRC-1:0]   en_wdata;
  logic                 clr_we;
  logic [NUM_SRC-1:0]   clr_wdata;
  logic                 irq_ack;
  logic                 irq_req;
  logic [VEC_WIDTH-1:0] irq_vec;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   enable;

  modport master (
    output src_in, en_we, en_wdata, clr_we, clr_wdata, irq_ack,
    input  irq_req, irq_vec, pending, enable
  );

  modport slave (
    input  src_in, en_we, en_wdata, clr_we, clr_wdata, irq_ack,
    output irq_req, irq_vec, pending, enable
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
//  req   : request vector
//  idx   : index of the lowest set bit (0 when none)
//  valid : any bit of req set
module irq_prio_enc #(
  parameter int unsigned NUM_SRC   = 12,
  parameter int unsigned VEC_WIDTH = 4
) (
  input  logic [NUM_SRC-1:0]   req,
  output logic [VEC_WIDTH-1:0] idx,
  output logic                 valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = VEC_WIDTH'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: folds the 12 timer strobes into one vectored CPU request.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus.src_in : strobes; rising edges set pending bits regardless of enable
//  bus.en_*   : enable-mask write;  bus.clr_* : write-1-to-clear of pending bits
//  bus.irq_ack: CPU acknowledge pulse, honoured only while irq_req is high
//  bus.irq_req/irq_vec : request and the frozen winning source index
//  bus.pending/enable  : register readback
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 12,
  parameter int unsigned VEC_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  timer_irq_ctrl_if.slave bus
);

  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic [NUM_SRC-1:0]   src_rise, clr_mask, active;
  logic [VEC_WIDTH-1:0] vec_q, vec_d, winner;
  logic                 any_active, ack_clear;
  irq_state_e           state_q, state_d;

  assign src_rise = bus.src_in & ~src_q;
  assign active   = pending_q & enable_q;

  irq_prio_enc #(
    .NUM_SRC  (NUM_SRC),
    .VEC_WIDTH(VEC_WIDTH)
  ) u_prio_enc (
    .req  (active),
    .idx  (winner),
    .valid(any_active)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    ack_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_active) begin
          state_d = StReq;
          vec_d   = winner;
        end
      end
      StReq: begin
        // Ack beats withdrawal; a higher-priority arrival never preempts.
        if (bus.irq_ack) begin
          ack_clear = 1'b1;
          state_d   = StGap;
        end else if (!active[vec_q]) begin
          state_d = StIdle;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clr_mask = (bus.clr_we ? bus.clr_wdata : '0) |
               (ack_clear ? (NUM_SRC'(1) << vec_q) : '0);
    // New edges override any clear in the same cycle.
    pending_d = (pending_q & ~clr_mask) | src_rise;
    enable_d  = bus.en_we ? bus.en_wdata : enable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      vec_q     <= '0;
      state_q   <= StIdle;
    end else begin
      src_q     <= bus.src_in;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      vec_q     <= vec_d;
      state_q   <= state_d;
    end
  end

  assign bus.irq_req = (state_q == StReq);
  assign bus.irq_vec = vec_q;
  assign bus.pending = pending_q;
  assign bus.enable  = enable_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  timer_irq_ctrl_if #(.NUM_SRC(12), .VEC_WIDTH(4)) bus ();

  timer_irq_ctrl #(.NUM_SRC(12), .VEC_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: request/gap flags plus plain bit-vector arithmetic.
  logic [11:0] m_src, m_pend, m_en;
  bit          m_req, m_gap;
  int          m_vec;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_src = '0; m_pend = '0; m_en = '0;
    m_req = 0; m_gap = 0; m_vec = 0;
  endtask

  // Advance the model by one clock using the inputs currently presented.
  task automatic model_step();
    logic [11:0] act, clr;
    int a;
    act = m_pend & m_en;
    clr = bus.clr_we ? bus.clr_wdata : 12'h000;
    if (m_req) begin
      if (bus.irq_ack) begin
        clr   = clr | 12'(1 << m_vec);
        m_req = 0;
        m_gap = 1;
      end else if (act[m_vec] == 1'b0) begin
        m_req = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (act != 0) begin
      a     = int'(act);
      m_vec = $clog2(a & -a);  // index of lowest set bit
      m_req = 1;
    end
    m_pend = (m_pend & ~clr) | (bus.src_in & ~m_src);
    if (bus.en_we) m_en = bus.en_wdata;
    m_src = bus.src_in;
  endtask

  task automatic check_outputs();
    chk("irq_req", int'(bus.irq_req), int'(m_req));
    chk("pending", int'(bus.pending), int'(m_pend));
    chk("enable",  int'(bus.enable),  int'(m_en));
    if (m_req) chk("irq_vec", int'(bus.irq_vec), m_vec);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    bus.en_we   = 1'b0;
    bus.clr_we  = 1'b0;
    bus.irq_ack = 1'b0;
  endtask

  task automatic pulse(input logic [11:0] bits);
    bus.src_in = bits;
    tick();
    bus.src_in = '0;
  endtask

  task automatic write_en(input logic [11:0] val);
    bus.en_we    = 1'b1;
    bus.en_wdata = val;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.src_in    = '0;
    bus.en_we     = 1'b0;
    bus.en_wdata  = '0;
    bus.clr_we    = 1'b0;
    bus.clr_wdata = '0;
    bus.irq_ack   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq_req", int'(bus.irq_req), 0);
    chk("rst_irq_vec", int'(bus.irq_vec), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_enable",  int'(bus.enable),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Single CMIB1 pulse, two-cycle latency, ack and gap.
    write_en(12'hFFF); tick();
    pulse(12'(1 << SRC_CMIB1));
    chk("t1_no_req_yet", int'(bus.irq_req), 0);
    tick();
    chk("t1_req", int'(bus.irq_req), 1);
    chk("t1_vec", int'(bus.irq_vec), 4);
    bus.irq_ack = 1'b1; tick();
    chk("t1_pend4_clr", int'(bus.pending[4]), 0);
    chk("t1_gap0", int'(bus.irq_req), 0);
    tick();
    chk("t1_gap1", int'(bus.irq_req), 0);

    // 2. Simultaneous edges on 2, 7, 11 served in priority order.
    pulse(12'h884);
    tick();
    chk("t2_vec_a", int'(bus.irq_vec), 2);
    bus.irq_ack = 1'b1; tick();
    tick();
    chk("t2_idle", int'(bus.irq_req), 0);
    tick();
    chk("t2_req_b", int'(bus.irq_req), 1);
    chk("t2_vec_b", int'(bus.irq_vec), 7);
    bus.irq_ack = 1'b1; tick();
    tick(); tick();
    chk("t2_req_c", int'(bus.irq_req), 1);
    chk("t2_vec_c", int'(bus.irq_vec), 11);
    bus.irq_ack = 1'b1; tick();
    tick();

    // 3. Masked source stays pending; enabling it raises the request.
    write_en(12'h000); tick();
    pulse(12'h001);
    tick();
    chk("t3_pending", int'(bus.pending), 12'h001);
    chk("t3_masked", int'(bus.irq_req), 0);
    write_en(12'h001); tick();
    tick();
    chk("t3_req", int'(bus.irq_req), 1);
    chk("t3_vec", int'(bus.irq_vec), 0);
    bus.irq_ack = 1'b1; tick();
    tick();

    // 4. Withdrawal by software clear, then by masking.
    write_en(12'hFFF); tick();
    pulse(12'h020);
    tick();
    chk("t4_req_a", int'(bus.irq_req), 1);
    bus.clr_we = 1'b1; bus.clr_wdata = 12'h020; tick();
    tick();
    chk("t4_withdraw_clr", int'(bus.irq_req), 0);
    pulse(12'h020);
    tick();
    chk("t4_req_b", int'(bus.irq_req), 1);
    write_en(12'hFDF); tick();
    tick();
    chk("t4_withdraw_mask", int'(bus.irq_req), 0);
    write_en(12'hFFF);
    bus.clr_we = 1'b1; bus.clr_wdata = 12'h020; tick();
    tick();

    // 5. Re-arrival in the ack cycle: set wins, request repeats after gap.
    pulse(12'h008);
    tick();
    chk("t5_vec", int'(bus.irq_vec), 3);
    bus.src_in = 12'h008; bus.irq_ack = 1'b1; tick();
    bus.src_in = '0;
    chk("t5_pend3_kept", int'(bus.pending[3]), 1);
    tick(); tick();
    chk("t5_req_again", int'(bus.irq_req), 1);
    chk("t5_vec_again", int'(bus.irq_vec), 3);
    bus.irq_ack = 1'b1; tick();
    tick();

    // 6. Asynchronous reset in the middle of a request.
    pulse(12'h040);
    tick();
    chk("t6_req", int'(bus.irq_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req",  int'(bus.irq_req), 0);
    chk("t6_rst_pend", int'(bus.pending), 0);
    chk("t6_rst_en",   int'(bus.enable),  0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    write_en(12'hFFF); tick();
    repeat (3) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.src_in = 12'($urandom) & 12'($urandom) & 12'($urandom);
      if ($urandom_range(15, 0) == 0) write_en(12'($urandom));
      if ($urandom_range(7, 0) == 0) begin
        bus.clr_we    = 1'b1;
        bus.clr_wdata = 12'($urandom);
      end
      if (m_req) bus.irq_ack = ($urandom_range(1, 0) == 1);
      else       bus.irq_ack = ($urandom_range(9, 0) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
